// File: rtl/operand_entry_pkg.sv
// operand_entry_pkg
//   Shared definitions for the operand entry front end and the display/LED
//   logic that reports the current entry phase.
//   - PH_* : phase encoding driven on operand_entry.phase
//   - state_e : FSM state type, values equal to the PH_* encodings
//   - DEFAULT_DEBOUNCE_CYCLES : debounce window for the board clock
package operand_entry_pkg;

  localparam logic [1:0] PH_LOAD_A = 2'b00;
  localparam logic [1:0] PH_LOAD_B = 2'b01;
  localparam logic [1:0] PH_SHOW   = 2'b10;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  typedef enum logic [1:0] {
    ST_LOAD_A = PH_LOAD_A,
    ST_LOAD_B = PH_LOAD_B,
    ST_SHOW   = PH_SHOW
  } state_e;

endpackage

// File: rtl/operand_entry_button_debouncer.sv
// button_debouncer
//   Synchronises one raw pushbutton, debounces it and emits a single-cycle
//   press pulse the cycle after the debounced level rises.
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset
//     raw   : raw, bouncy, asynchronous button input (active-high)
//     level : debounced button level
//     press : one-cycle pulse per accepted press (none on release)
module button_debouncer
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  // Sized so the counter can hold DEBOUNCE_CYCLES without wrapping.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;
  logic             press_q, press_d;

  // Next-state logic for synchroniser, debounce counter and press pulse.
  always_comb begin
    sync1_d      = raw;
    sync2_d      = sync1_q;
    cnt_d        = '0;
    level_d      = level_q;
    level_prev_d = level_q;
    // Registered rising edge of the debounced level: the pulse lands one
    // cycle after level_q rises, and releases never fire.
    press_d      = level_q & ~level_prev_q;
    if (sync2_q != level_q) begin
      // The edge that would bring the count to DEBOUNCE_CYCLES accepts the
      // new level instead, so the counter itself never holds that value.
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/operand_entry.sv
// operand_entry
//   Front end that collects operand A, operand B and the add/subtract op
//   for the 4-bit datapath, stepping LOAD_A -> LOAD_B -> SHOW on each
//   debounced enter press. Clear returns to LOAD_A with zeroed operands.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     sw         : raw data switches (asynchronous)
//     op_sw      : raw op switch, 0 = add, 1 = subtract (asynchronous)
//     btn_enter  : raw enter button (active-high, bouncy)
//     btn_clear  : raw clear button (active-high, bouncy)
//     a, b       : registered operands
//     op_code    : registered op, latched with b
//     phase      : current phase (PH_* encoding)
//     valid      : high only in SHOW
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             op_sw,
  input  logic             btn_enter,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             op_code,
  output logic [1:0]       phase,
  output logic             valid
);

  logic enter_press_s;
  logic clear_press_s;
  logic unused_enter_level_s;
  logic unused_clear_level_s;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_enter),
    .level (unused_enter_level_s),
    .press (enter_press_s)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_clear),
    .level (unused_clear_level_s),
    .press (clear_press_s)
  );

  logic [WIDTH-1:0] sw_sync1_q, sw_sync1_d;
  logic [WIDTH-1:0] sw_sync2_q, sw_sync2_d;
  logic             op_sync1_q, op_sync1_d;
  logic             op_sync2_q, op_sync2_d;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_code_q, op_code_d;
  logic             valid_q, valid_d;

  // Switch synchronisers; only sw_sync2_q / op_sync2_q are ever latched.
  always_comb begin
    sw_sync1_d = sw;
    sw_sync2_d = sw_sync1_q;
    op_sync1_d = op_sw;
    op_sync2_d = op_sync1_q;
  end

  // Entry FSM next state and operand latching; clear overrides enter.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_code_d = op_code_q;
    if (clear_press_s) begin
      state_d   = ST_LOAD_A;
      a_d       = '0;
      b_d       = '0;
      op_code_d = 1'b0;
    end else if (enter_press_s) begin
      case (state_q)
        ST_LOAD_A: begin
          a_d     = sw_sync2_q;
          state_d = ST_LOAD_B;
        end
        ST_LOAD_B: begin
          b_d       = sw_sync2_q;
          op_code_d = op_sync2_q;
          state_d   = ST_SHOW;
        end
        ST_SHOW: begin
          state_d = ST_LOAD_A;
        end
        default: begin
          state_d = ST_LOAD_A;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    // Registered so valid switches on the same edge as phase.
    valid_d = (state_d == ST_SHOW);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      op_sync1_q <= 1'b0;
      op_sync2_q <= 1'b0;
      state_q    <= ST_LOAD_A;
      a_q        <= '0;
      b_q        <= '0;
      op_code_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      sw_sync1_q <= sw_sync1_d;
      sw_sync2_q <= sw_sync2_d;
      op_sync1_q <= op_sync1_d;
      op_sync2_q <= op_sync2_d;
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_code_q  <= op_code_d;
      valid_q    <= valid_d;
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign op_code = op_code_q;
  assign phase   = state_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry
//   Scoreboard bench for operand_entry with a 4-cycle debounce window.
//   Expected entries are queued when a press is driven and compared when the
//   DUT's phase changes.
module tb_operand_entry;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       op_sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [3:0] a;
  logic [3:0] b;
  logic       op_code;
  logic [1:0] phase;
  logic       valid;

  operand_entry #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .op_sw     (op_sw),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .a         (a),
    .b         (b),
    .op_code   (op_code),
    .phase     (phase),
    .valid     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       op;
    logic [1:0] ph;
    logic       v;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] ea, input logic [3:0] eb,
                              input logic eo, input logic [1:0] ep, input logic ev);
    exp_t e;
    e.a = ea; e.b = eb; e.op = eo; e.ph = ep; e.v = ev;
    return e;
  endfunction

  task automatic compare_entry(input string tag);
    exp_t e;
    check_val({tag, "_sb_pending"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({tag, "_a"},     32'(a),       32'(e.a));
      check_val({tag, "_b"},     32'(b),       32'(e.b));
      check_val({tag, "_op"},    32'(op_code), 32'(e.op));
      check_val({tag, "_phase"}, 32'(phase),   32'(e.ph));
      check_val({tag, "_valid"}, 32'(valid),   32'(e.v));
    end
  endtask

  // Wait (bounded) for a phase change, check edge count and the entry.
  task automatic await_change(input string tag, input int exp_edges);
    logic [1:0] prev;
    int         edges;
    prev  = phase;
    edges = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (phase !== prev) begin
        edges = i;
        break;
      end
    end
    check_val({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    if (edges > 0) compare_entry(tag);
  endtask

  // Run n cycles; every phase change pops and compares the scoreboard.
  task automatic run_cycles(input string tag, input int n, output int changes);
    logic [1:0] prev;
    changes = 0;
    for (int i = 0; i < n; i++) begin
      prev = phase;
      @(posedge clk);
      #1;
      if (phase !== prev) begin
        changes++;
        compare_entry(tag);
      end
    end
  endtask

  task automatic press_enter(input string tag, input logic [3:0] s, input logic o, input exp_t e);
    int ch;
    @(negedge clk);
    sw    = s;
    op_sw = o;
    repeat (3) @(negedge clk);
    btn_enter = 1'b1;
    sb_q.push_back(e);
    await_change(tag, 8);
    @(negedge clk);
    btn_enter = 1'b0;
    run_cycles({tag, "_rel"}, 10, ch);
    check_val({tag, "_no_release_pulse"}, 32'(ch), 32'd0);
  endtask

  initial begin
    int ch;
    int total;
    rst_n     = 1'b0;
    sw        = 4'h0;
    op_sw     = 1'b0;
    btn_enter = 1'b0;
    btn_clear = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_a",     32'(a),       32'd0);
    check_val("rst_b",     32'(b),       32'd0);
    check_val("rst_op",    32'(op_code), 32'd0);
    check_val("rst_phase", 32'(phase),   32'd0);
    check_val("rst_valid", 32'(valid),   32'd0);
    rst_n = 1'b1;
    run_cycles("idle", 5, ch);
    check_val("idle_changes", 32'(ch), 32'd0);

    // Clean sequence
    press_enter("load_a", 4'h3, 1'b0, mk(4'h3, 4'h0, 1'b0, 2'b01, 1'b0));
    press_enter("load_b", 4'h5, 1'b1, mk(4'h3, 4'h5, 1'b1, 2'b10, 1'b1));

    // SHOW wrap holds operands; switch changes are ignored afterwards
    press_enter("wrap", 4'h5, 1'b1, mk(4'h3, 4'h5, 1'b1, 2'b00, 1'b0));
    @(negedge clk);
    sw = 4'hF;
    run_cycles("sw_no_press", 10, ch);
    check_val("sw_no_press_changes", 32'(ch), 32'd0);
    check_val("sw_no_press_a", 32'(a), 32'h3);
    check_val("sw_no_press_b", 32'(b), 32'h5);

    // Hold enter 50 cycles in LOAD_A: single advance
    sb_q.push_back(mk(4'hF, 4'h5, 1'b1, 2'b01, 1'b0));
    @(negedge clk);
    btn_enter = 1'b1;
    run_cycles("hold", 50, ch);
    check_val("hold_changes", 32'(ch), 32'd1);
    @(negedge clk);
    btn_enter = 1'b0;
    run_cycles("hold_rel", 10, ch);
    check_val("hold_rel_changes", 32'(ch), 32'd0);

    // Bounce 1,0,1,0 at 2-cycle intervals then hold: one advance
    @(negedge clk);
    sw    = 4'h6;
    op_sw = 1'b0;
    repeat (3) @(negedge clk);
    sb_q.push_back(mk(4'hF, 4'h6, 1'b0, 2'b10, 1'b1));
    total = 0;
    for (int k = 0; k < 4; k++) begin
      btn_enter = (k % 2 == 0) ? 1'b1 : 1'b0;
      run_cycles("bounce", 2, ch);
      total += ch;
      @(negedge clk);
    end
    btn_enter = 1'b1;
    run_cycles("bounce_hold", 10, ch);
    total += ch;
    check_val("bounce_changes", 32'(total), 32'd1);
    @(negedge clk);
    btn_enter = 1'b0;
    run_cycles("bounce_rel", 10, ch);
    check_val("bounce_rel_changes", 32'(ch), 32'd0);

    // 3-cycle glitch alone: no advance
    @(negedge clk);
    btn_enter = 1'b1;
    run_cycles("glitch", 3, ch);
    total = ch;
    @(negedge clk);
    btn_enter = 1'b0;
    run_cycles("glitch_after", 12, ch);
    total += ch;
    check_val("glitch_changes", 32'(total), 32'd0);

    // Get to LOAD_B, then clear and enter together: clear wins
    press_enter("to_a", 4'h6, 1'b0, mk(4'hF, 4'h6, 1'b0, 2'b00, 1'b0));
    press_enter("to_b", 4'h2, 1'b1, mk(4'h2, 4'h6, 1'b0, 2'b01, 1'b0));
    @(negedge clk);
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    sb_q.push_back(mk(4'h0, 4'h0, 1'b0, 2'b00, 1'b0));
    await_change("clear", 8);
    @(negedge clk);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    run_cycles("clear_rel", 10, ch);
    check_val("clear_rel_changes", 32'(ch), 32'd0);

    // Async reset 2 cycles into an enter debounce in LOAD_B
    press_enter("pre_rst", 4'h9, 1'b0, mk(4'h9, 4'h0, 1'b0, 2'b01, 1'b0));
    @(negedge clk);
    btn_enter = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("arst_a",     32'(a),       32'd0);
    check_val("arst_phase", 32'(phase),   32'd0);
    check_val("arst_valid", 32'(valid),   32'd0);
    check_val("arst_op",    32'(op_code), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Full sync + debounce + pulse + latch from release: no stale pulse.
    sb_q.push_back(mk(4'h9, 4'h0, 1'b0, 2'b01, 1'b0));
    await_change("post_rst", 8);
    @(negedge clk);
    btn_enter = 1'b0;
    run_cycles("post_rst_rel", 10, ch);
    check_val("post_rst_rel_changes", 32'(ch), 32'd0);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
